// File: rtl/select_scheduler.sv
// Round-robin select scheduler: snapshots a request vector on start and issues one index at a time, each held for HOLD cycles.
// Optional grant counter port enabled by defining SELECT_SCHEDULER_GRANT_CNT_EN.
module select_scheduler #(
    parameter int N_REQ = 8,
    parameter int SEL_W = $clog2(N_REQ),
    parameter int HOLD  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_REQ-1:0] req,
    output logic [SEL_W-1:0] select,
    output logic             sel_valid,
    output logic             busy,
    output logic             done
`ifdef SELECT_SCHEDULER_GRANT_CNT_EN
    ,
    output logic [15:0]      grant_cnt
`endif
);

    localparam int HW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t           state;
    logic [N_REQ-1:0] pending;
    logic [SEL_W-1:0] rr_ptr;
    logic [HW-1:0]    hold_cnt;

    logic [N_REQ-1:0] src;
    logic [N_REQ-1:0] src_clr;
    logic [SEL_W-1:0] pick;
    logic             grant_fire;

    // Scanning downward lets the lowest offset from ptr win; the index wraps because N_REQ is a power of 2.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] vec,
                                                 input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] idx;
        rr_pick = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (vec[idx]) rr_pick = idx;
        end
    endfunction

    // NOTE: every always_comb output is assigned unconditionally so no latch can be inferred.
    always_comb begin
        src           = (state == IDLE) ? req : pending;
        pick          = rr_pick(src, rr_ptr);
        src_clr       = src;
        src_clr[pick] = 1'b0;
        grant_fire    = ((state == IDLE) && start && (req != '0)) ||
                        ((state == ISSUE) && (hold_cnt == '0) && (pending != '0));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            select    <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pending   <= '0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
        end else begin
            if (grant_fire) begin
                select    <= pick;
                sel_valid <= 1'b1;
                pending   <= src_clr;
                rr_ptr    <= pick + SEL_W'(1);
                hold_cnt  <= HW'(HOLD - 1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (req != '0) begin
                            state <= ISSUE;
                        end else begin
                            pending <= '0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end else if (pending == '0) begin
                        sel_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SELECT_SCHEDULER_GRANT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt <= '0;
        end else if (grant_fire && (grant_cnt != 16'hFFFF)) begin
            grant_cnt <= grant_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_select_scheduler.sv
// Self-checking bench for select_scheduler: directed runs plus randomized runs against a queue-based round-robin model.
module tb_select_scheduler;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;
    localparam int HOLD  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [N_REQ-1:0] req = '0;
    logic [SEL_W-1:0] select;
    logic             sel_valid;
    logic             busy;
    logic             done;
`ifdef SELECT_SCHEDULER_GRANT_CNT_EN
    logic [15:0]      grant_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    int model_ptr = 0;
    int model_sel = 0;
    int model_cnt = 0;

    select_scheduler #(.N_REQ(N_REQ), .HOLD(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .req       (req),
        .select    (select),
        .sel_valid (sel_valid),
        .busy      (busy),
        .done      (done)
`ifdef SELECT_SCHEDULER_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_cnt(input string tag);
`ifdef SELECT_SCHEDULER_GRANT_CNT_EN
        check(tag, 32'(grant_cnt), 32'(model_cnt));
`endif
    endtask

    // One full run: the expected grant order is every set bit visited circularly once, starting at the pointer.
    task automatic run(input logic [N_REQ-1:0] r, input bit noisy);
        int seq[$];
        int total;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (model_ptr + k) % N_REQ;
            if (r[idx]) seq.push_back(idx);
        end
        total = seq.size() * HOLD;

        @(negedge clk);
        req   = r;
        start = 1'b1;
        @(negedge clk);
        for (int c = 0; c <= total; c++) begin
            if (c < total) begin
                check("sel_valid", 32'(sel_valid), 32'd1);
                check("select", 32'(select), 32'(seq[c / HOLD]));
                check("busy", 32'(busy), 32'd1);
                check("done_low", 32'(done), 32'd0);
            end else begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_done", 32'(busy), 32'd1);
                check("valid_done", 32'(sel_valid), 32'd0);
                check("select_hold", 32'(select), 32'(seq.size() > 0 ? seq[$] : model_sel));
            end
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                req   = N_REQ'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_valid", 32'(sel_valid), 32'd0);
        if (seq.size() > 0) begin
            model_sel = seq[$];
            model_ptr = (seq[$] + 1) % N_REQ;
            model_cnt += seq.size();
        end
        check("idle_select", 32'(select), 32'(model_sel));
    endtask

    initial begin
        #12;
        check("rst_select", 32'(select), 32'd0);
        check("rst_valid", 32'(sel_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_cnt("rst_cnt");
        @(negedge clk);
        rst = 1'b0;

        run(8'hFF, 1'b0);
        run(8'b1010_0100, 1'b0);
        check("ptr_after_t2", 32'(model_ptr), 32'd0);
        check_cnt("cnt_t1_t2");
        run(8'h24, 1'b0);
        run(8'h41, 1'b0);
        run(8'h00, 1'b0);
        run(8'hFF, 1'b1);

        for (int i = 0; i < 25; i++) begin
            run(N_REQ'($urandom), 1'b1);
        end
        check_cnt("cnt_random");

        // Reset in the middle of a hold period.
        @(negedge clk);
        req   = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_select", 32'(select), 32'd0);
        check("midrst_valid", 32'(sel_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        model_ptr = 0;
        model_sel = 0;
        model_cnt = 0;
        check_cnt("midrst_cnt");
        @(negedge clk);
        rst = 1'b0;
        run(8'h81, 1'b0);
        run(8'h81, 1'b0);
        check_cnt("cnt_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
